// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer.
// Drives the external PC register through one-cycle clear/increment/load
// strobes, reads the PC back, fetches the instruction word over a simple
// request/ready memory handshake and presents it to the execute stage.
// A taken branch reported by the execute stage is applied to the PC by a
// load strobe before the next fetch. Fetching stops on the halt opcode.

module fetch_seq #(
    parameter int                ADDR_W  = 8,
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] HALT_OP = 8'hFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc_value,
    output logic              pc_load,
    output logic              pc_clr,
    output logic              pc_inc,
    output logic [ADDR_W-1:0] pc_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              exec_done,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              halted,
    output logic [15:0]       instr_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_ADDR   = 3'd2,
        ST_READ   = 3'd3,
        ST_INC    = 3'd4,
        ST_EXEC   = 3'd5,
        ST_BRANCH = 3'd6,
        ST_HALT   = 3'd7
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_data_q, pc_data_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [15:0]       instr_count_q, instr_count_d;

    // A returned word is the halt opcode; decides HALT vs normal fetch path.
    logic              rdata_is_halt;
    assign rdata_is_halt = (mem_rdata == HALT_OP);

    // State and datapath registers; reset returns to IDLE with cleared datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_data_q     <= '0;
            mem_addr_q    <= '0;
            ir_q          <= '0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_data_q     <= pc_data_d;
            mem_addr_q    <= mem_addr_d;
            ir_q          <= ir_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Next-state and datapath update; each input is only looked at in the
    // state that owns it, so stray pulses elsewhere have no effect.
    always_comb begin
        state_d       = state_q;
        pc_data_d     = pc_data_q;
        mem_addr_d    = mem_addr_q;
        ir_d          = ir_q;
        instr_count_d = instr_count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                end
            end

            // PC register clears on the edge leaving this state.
            ST_CLEAR: begin
                state_d = ST_ADDR;
            end

            // Every strobe state is at least one edge behind us, so the
            // PC read-back is settled and can be latched as the address.
            ST_ADDR: begin
                mem_addr_d = pc_value;
                state_d    = ST_READ;
            end

            // Address held stable while waiting on the memory.
            ST_READ: begin
                if (mem_ready) begin
                    ir_d = mem_rdata;
                    if (rdata_is_halt) begin
                        state_d = ST_HALT;
                    end else begin
                        instr_count_d = instr_count_q + 16'd1;
                        state_d       = ST_INC;
                    end
                end
            end

            // PC advances past the fetched word before execution starts,
            // so a branch target simply overrides the incremented value.
            ST_INC: begin
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                if (exec_done) begin
                    if (branch_taken) begin
                        pc_data_d = branch_target;
                        state_d   = ST_BRANCH;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end

            // Target is registered, so pc_data is stable for the whole load.
            ST_BRANCH: begin
                state_d = ST_ADDR;
            end

            ST_HALT: begin
                if (start) begin
                    state_d = ST_CLEAR;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Moore output decode: strobes and handshakes depend on state only,
    // which guarantees at most one PC strobe per cycle.
    always_comb begin
        pc_clr   = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        mem_rd   = 1'b0;
        ir_valid = 1'b0;
        halted   = 1'b0;

        unique case (state_q)
            ST_CLEAR:  pc_clr   = 1'b1;
            ST_READ:   mem_rd   = 1'b1;
            ST_INC:    pc_inc   = 1'b1;
            ST_EXEC:   ir_valid = 1'b1;
            ST_BRANCH: pc_load  = 1'b1;
            ST_HALT:   halted   = 1'b1;
            default: begin
                pc_clr = 1'b0;
            end
        endcase
    end

    assign pc_data     = pc_data_q;
    assign mem_addr    = mem_addr_q;
    assign ir          = ir_q;
    assign instr_count = instr_count_q;

endmodule
